pipe_reg_bank_elastic: RTL and testbench

//  Parametrised multi-channel pipeline register bank: NUM_CH lanes of WIDTH bits

---
 rtl/pipe_reg_bank_elastic_if.sv | 30 +++
 rtl/pipe_reg_bank_elastic.sv | 85 ++++++++
 tb/tb_pipe_reg_bank_elastic.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_bank_elastic_if.sv
// Bus bundle for the elastic register bank: control, input beat, output beat, occupancy.
// A beat moves only at a rising edge where valid and ready are both 1; valid never waits on ready.
interface pipe_reg_bank_elastic_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 2
);
   localparam int BW = WIDTH * NUM_CH;
   localparam int OW = $clog2(DEPTH + 1);

   logic          enable;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic [OW-1:0] occupancy;

   modport master (
      output enable, flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  enable, flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/pipe_reg_bank_elastic.sv
// NUM_CH x WIDTH beats carried through DEPTH elastic stages with bubble collapsing,
// flush, global enable and a registered occupancy count.
module pipe_reg_bank_elastic #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 2
) (
   input logic                   clock,
   input logic                   reset,
   pipe_reg_bank_elastic_if.slave bus
);
   localparam int BW = WIDTH * NUM_CH;
   localparam int OW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] v_nxt;
   logic [DEPTH-1:0] adv;
   logic [BW-1:0]    d [DEPTH];
   logic [OW-1:0]    occ;
   logic [OW-1:0]    occ_nxt;
   logic             advance;

   assign advance = bus.enable & ~bus.flush;

   // A stage may move when any stage at or after it is empty or the output drains;
   // written as a flat OR so the ready chain has no self-referencing vector.
   always_comb begin
      logic any_free;
      any_free = 1'b0;
      adv      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         any_free = bus.out_ready;
         for (int j = i; j < DEPTH; j++) begin
            any_free = any_free | ~v[j];
         end
         adv[i] = any_free;
      end
   end

   always_comb begin
      v_nxt = v;
      if (bus.flush) begin
         v_nxt = '0;
      end else if (bus.enable) begin
         if (adv[0]) v_nxt[0] = bus.in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) v_nxt[i] = v[i-1];
         end
      end
   end

   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_nxt = occ_nxt + OW'(v_nxt[i]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v   <= '0;
         occ <= '0;
      end else begin
         v   <= v_nxt;
         occ <= occ_nxt;
      end
   end

   // Data only loads from a valid source, so an emptied stage keeps its last beat.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      end else if (advance) begin
         if (adv[0] && bus.in_valid) d[0] <= bus.in_data;
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i] && v[i-1]) d[i] <= d[i-1];
         end
      end
   end

   assign bus.in_ready  = advance & adv[0];
   assign bus.out_valid = bus.enable & v[DEPTH-1];
   assign bus.out_data  = d[DEPTH-1];
   assign bus.occupancy = occ;
endmodule

// File: tb/tb_pipe_reg_bank_elastic.sv
// Bench for pipe_reg_bank_elastic: per-cycle vector table, random backpressure stream,
// and an asynchronous reset sequence, all backed by an expected-beat queue.
module tb_pipe_reg_bank_elastic;
   localparam int WIDTH  = 32;
   localparam int NUM_CH = 4;
   localparam int DEPTH  = 2;
   localparam int BW     = WIDTH * NUM_CH;
   localparam int OW     = $clog2(DEPTH + 1);
   localparam int NVEC   = 21;

   logic clock = 1'b0;
   logic reset = 1'b0;

   pipe_reg_bank_elastic_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

   pipe_reg_bank_elastic #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [BW-1:0] exp_q[$];
   int n_cmp = 0;
   int n_fail = 0;
   int n_out = 0;

   typedef struct {
      logic          en;
      logic          fl;
      logic          iv;
      logic [7:0]    base;
      logic          ordy;
      logic          exp_ir;
      logic          exp_ov;
      logic [OW-1:0] exp_occ;
   } vec_t;

   vec_t tbl[NVEC];

   function automatic logic [BW-1:0] mk_beat(input logic [7:0] base);
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < NUM_CH; k++) b[k*WIDTH +: WIDTH] = WIDTH'(base + 8'(k));
      return b;
   endfunction

   function automatic vec_t mkv(input logic en, input logic fl, input logic iv,
                                input logic [7:0] base, input logic ordy,
                                input logic ir, input logic ov, input logic [OW-1:0] occ);
      vec_t r;
      r.en = en; r.fl = fl; r.iv = iv; r.base = base; r.ordy = ordy;
      r.exp_ir = ir; r.exp_ov = ov; r.exp_occ = occ;
      return r;
   endfunction

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_num(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_data(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive, sample at the falling edge, update the scoreboard, advance.
   task automatic step(input logic en, input logic fl, input logic iv, input logic [BW-1:0] data,
                       input logic ordy, output logic s_ir, output logic s_ov,
                       output int s_occ, output int q_sz);
      logic [BW-1:0] got;
      bus.enable    = en;
      bus.flush     = fl;
      bus.in_valid  = iv;
      bus.in_data   = data;
      bus.out_ready = ordy;
      @(negedge clock);
      s_ir  = bus.in_ready;
      s_ov  = bus.out_valid;
      s_occ = int'(bus.occupancy);
      q_sz  = exp_q.size();
      got   = bus.out_data;
      if (s_ov && ordy) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out_beat: got %0h expected no beat", got);
         end else begin
            check_data("out_beat", got, exp_q.pop_front());
         end
      end
      if (iv && s_ir) exp_q.push_back(data);
      if (fl) exp_q.delete();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic          ir;
      logic          ov;
      logic          rdy;
      int            occ;
      int            qs;
      int            out0;
      int            sent;
      int            cyc;
      logic [BW-1:0] rb[8];

      //            en    fl    iv    base   ordy   ir    ov    occ
      tbl[0]  = mkv(1'b1, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 2'd0);
      tbl[1]  = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd1);
      tbl[2]  = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1);
      tbl[3]  = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0);
      tbl[4]  = mkv(1'b1, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 2'd0);
      tbl[5]  = mkv(1'b1, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 1'b0, 2'd1);
      tbl[6]  = mkv(1'b1, 1'b0, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b1, 2'd2);
      tbl[7]  = mkv(1'b1, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 2'd2);
      tbl[8]  = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2);
      tbl[9]  = mkv(1'b0, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 2'd1);
      tbl[10] = mkv(1'b0, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 2'd1);
      tbl[11] = mkv(1'b0, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 2'd1);
      tbl[12] = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1);
      tbl[13] = mkv(1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 2'd0);
      tbl[14] = mkv(1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 2'd1);
      tbl[15] = mkv(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 2'd2);
      tbl[16] = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0);
      tbl[17] = mkv(1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 2'd0);
      tbl[18] = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd1);
      tbl[19] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1);
      tbl[20] = mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0);

      bus.enable    = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      #12;
      check_bit("reset_out_valid", bus.out_valid, 1'b0);
      check_num("reset_occupancy", int'(bus.occupancy), 0);
      check_data("reset_out_data", bus.out_data, '0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Vector table: latency, fill/stall, simultaneous in/out, enable freeze, flush
      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].en, tbl[i].fl, tbl[i].iv, mk_beat(tbl[i].base), tbl[i].ordy, ir, ov, occ, qs);
         check_bit($sformatf("vec%0d_in_ready", i), ir, tbl[i].exp_ir);
         check_bit($sformatf("vec%0d_out_valid", i), ov, tbl[i].exp_ov);
         check_num($sformatf("vec%0d_occupancy", i), occ, int'(tbl[i].exp_occ));
      end
      check_num("vec_leftover_beats", exp_q.size(), 0);

      // Random backpressure stream of 8 beats
      for (int k = 0; k < 8; k++) begin
         for (int l = 0; l < NUM_CH; l++) rb[k][l*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      out0 = n_out;
      sent = 0;
      cyc  = 0;
      while ((n_out - out0) < 8 && cyc < 200) begin
         rdy = 1'($urandom_range(0, 1));
         step(1'b1, 1'b0, sent < 8, rb[(sent < 8) ? sent : 7], rdy, ir, ov, occ, qs);
         check_num("stream_occupancy", occ, qs);
         check_bit("stream_occ_bound", occ <= DEPTH, 1'b1);
         check_bit("stream_in_ready", ir, (qs < DEPTH) || rdy);
         if (sent < 8 && ir) sent++;
         cyc++;
      end
      check_num("stream_beats_out", n_out - out0, 8);
      check_num("stream_leftover", exp_q.size(), 0);

      // Asynchronous reset between edges while full
      step(1'b1, 1'b0, 1'b1, mk_beat(8'h40), 1'b0, ir, ov, occ, qs);
      check_bit("rst_fill0_in_ready", ir, 1'b1);
      step(1'b1, 1'b0, 1'b1, mk_beat(8'h50), 1'b0, ir, ov, occ, qs);
      check_bit("rst_fill1_in_ready", ir, 1'b1);
      bus.in_valid = 1'b0;
      #2;
      check_bit("pre_reset_out_valid", bus.out_valid, 1'b1);
      check_num("pre_reset_occupancy", int'(bus.occupancy), 2);
      reset = 1'b0;
      #1;
      check_bit("async_reset_out_valid", bus.out_valid, 1'b0);
      check_num("async_reset_occupancy", int'(bus.occupancy), 0);
      check_data("async_reset_out_data", bus.out_data, '0);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      step(1'b1, 1'b0, 1'b1, mk_beat(8'h60), 1'b1, ir, ov, occ, qs);
      check_bit("post_reset_in_ready", ir, 1'b1);
      check_bit("post_reset_c0_out_valid", ov, 1'b0);
      check_num("post_reset_c0_occupancy", occ, 0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, ir, ov, occ, qs);
      check_bit("post_reset_c1_out_valid", ov, 1'b0);
      check_num("post_reset_c1_occupancy", occ, 1);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, ir, ov, occ, qs);
      check_bit("post_reset_c2_out_valid", ov, 1'b1);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, ir, ov, occ, qs);
      check_bit("post_reset_c3_out_valid", ov, 1'b0);
      check_num("post_reset_leftover", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
